// File: rtl/la_pkg.sv
// Shared types for the logic-analyzer capture engine: FSM state encoding
// and trigger-mode codes.
package la_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRE      = 3'd1,
        ST_WAIT     = 3'd2,
        ST_POST     = 3'd3,
        ST_PREFETCH = 3'd4,
        ST_READ     = 3'd5
    } la_state_e;

    localparam logic [1:0] TRIG_PATTERN   = 2'd0;
    localparam logic [1:0] TRIG_ANY_EDGE  = 2'd1;
    localparam logic [1:0] TRIG_RISING    = 2'd2;
    localparam logic [1:0] TRIG_IMMEDIATE = 2'd3;

endpackage

// File: rtl/la_sample_ram.sv
// DEPTH x CHANNELS simple dual-port sample buffer: synchronous write,
// registered read with read enable so the output holds while stalled.
module la_sample_ram
    import la_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int DEPTH    = 64,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_we,
    input  logic [AW-1:0]       i_waddr,
    input  logic [CHANNELS-1:0] i_wdata,
    input  logic                i_re,
    input  logic [AW-1:0]       i_raddr,
    output logic [CHANNELS-1:0] o_rdata
);

    logic [CHANNELS-1:0] r_mem [DEPTH];
    logic [CHANNELS-1:0] r_rdata;

    // storage write port (no reset on the array)
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // registered read port, only the output register is reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyzer capture engine: synchronised probes sampled at a divided
// rate into a circular buffer, triggered, then streamed out oldest-first.
module la_capture_core
    import la_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int DEPTH    = 64,
    parameter int AW       = $clog2(DEPTH),
    parameter int DIV_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] probe,
    input  logic                arm,
    input  logic                abort,
    input  logic [DIV_W-1:0]    clk_div,
    input  logic [1:0]          trig_mode,
    input  logic [CHANNELS-1:0] trig_mask,
    input  logic [CHANNELS-1:0] trig_value,
    input  logic [AW-1:0]       pre_count,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [CHANNELS-1:0] rd_data,
    output logic                rd_last,
    output logic                triggered,
    output logic                busy,
    output logic [2:0]          state_o
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    la_state_e           r_state;
    logic [CHANNELS-1:0] r_sync1, r_sync2, r_prev;
    logic                r_prev_valid;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [1:0]          r_mode;
    logic [CHANNELS-1:0] r_mask, r_value;
    logic [AW-1:0]       r_pre, r_wr_ptr, r_trig_ptr, r_rd_ptr, r_post_left, r_beat;
    logic                r_rd_valid, r_rd_last, r_triggered;

    logic                w_strobe, w_arm_go, w_hit, w_we, w_re;
    logic [AW-1:0]       w_rd_start, w_raddr;
    logic [CHANNELS-1:0] w_rdata;

    assign w_strobe   = (r_div_cnt == clk_div);
    assign w_arm_go   = (r_state == ST_IDLE) && arm && !abort;
    assign w_we       = w_strobe && ((r_state == ST_PRE) || (r_state == ST_WAIT) || (r_state == ST_POST));
    assign w_rd_start = r_trig_ptr - r_pre;
    assign w_raddr    = (r_state == ST_PREFETCH) ? w_rd_start : r_rd_ptr;
    assign w_re       = (r_state == ST_PREFETCH) || ((r_state == ST_READ) && rd_ready);

    // two-flop probe synchroniser; r_sync2 is the sample register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= probe;
            r_sync2 <= r_sync1;
        end
    end

    // sample-rate divider, restarted when a capture is armed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_arm_go || w_strobe) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // trigger compare on the current strobe's sample
    always_comb begin
        w_hit = 1'b0;
        case (r_mode)
            TRIG_PATTERN:   w_hit = ((r_sync2 ^ r_value) & r_mask) == '0;
            TRIG_ANY_EDGE:  w_hit = r_prev_valid && (((r_sync2 ^ r_prev) & r_mask) != '0);
            TRIG_RISING:    w_hit = r_prev_valid && ((r_sync2 & ~r_prev & r_mask) != '0);
            TRIG_IMMEDIATE: w_hit = 1'b1;
            default:        w_hit = 1'b0;
        endcase
    end

    // capture / readout FSM with registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_mode       <= TRIG_PATTERN;
            r_mask       <= '0;
            r_value      <= '0;
            r_pre        <= '0;
            r_wr_ptr     <= '0;
            r_trig_ptr   <= '0;
            r_rd_ptr     <= '0;
            r_post_left  <= '0;
            r_beat       <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_triggered  <= 1'b0;
        end else if (abort) begin
            r_state     <= ST_IDLE;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_triggered <= 1'b0;
        end else begin
            if (w_we) begin
                r_wr_ptr     <= r_wr_ptr + AW'(1);
                r_prev       <= r_sync2;
                r_prev_valid <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_wr_ptr    <= '0;
                    r_triggered <= 1'b0;
                    r_rd_valid  <= 1'b0;
                    r_rd_last   <= 1'b0;
                    if (arm) begin
                        // pre_count is AW bits wide, so it never exceeds DEPTH-1
                        r_mode       <= trig_mode;
                        r_mask       <= trig_mask;
                        r_value      <= trig_value;
                        r_pre        <= pre_count;
                        r_prev_valid <= 1'b0;
                        r_state      <= (pre_count != '0) ? ST_PRE : ST_WAIT;
                    end
                end
                ST_PRE: begin
                    // wr_ptr starts at 0, so it doubles as the fill count here
                    if (w_strobe && (r_wr_ptr + AW'(1) == r_pre)) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_strobe && w_hit) begin
                        r_trig_ptr  <= r_wr_ptr;
                        r_triggered <= 1'b1;
                        r_post_left <= LAST_IDX - r_pre;
                        r_state     <= (r_pre == LAST_IDX) ? ST_PREFETCH : ST_POST;
                    end
                end
                ST_POST: begin
                    if (w_strobe) begin
                        r_post_left <= r_post_left - AW'(1);
                        if (r_post_left == AW'(1)) begin
                            r_state <= ST_PREFETCH;
                        end
                    end
                end
                ST_PREFETCH: begin
                    // first read issued this cycle; rd_ptr tracks the next one
                    r_rd_ptr   <= w_rd_start + AW'(1);
                    r_beat     <= '0;
                    r_rd_valid <= 1'b1;
                    r_rd_last  <= 1'b0;
                    r_state    <= ST_READ;
                end
                ST_READ: begin
                    if (rd_ready) begin
                        r_rd_ptr  <= r_rd_ptr + AW'(1);
                        r_beat    <= r_beat + AW'(1);
                        r_rd_last <= (r_beat + AW'(1) == LAST_IDX);
                        if (r_rd_last) begin
                            r_rd_valid <= 1'b0;
                            r_rd_last  <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    la_sample_ram #(
        .CHANNELS (CHANNELS),
        .DEPTH    (DEPTH),
        .AW       (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (r_sync2),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign rd_valid  = r_rd_valid;
    assign rd_data   = w_rdata;
    assign rd_last   = r_rd_last;
    assign triggered = r_triggered;
    assign busy      = (r_state != ST_IDLE);
    assign state_o   = r_state;

endmodule
